// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD digit type, limits and clamp helper
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  // Force an arbitrary nibble into legal BCD range
  function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit_updn.sv
// rtl/bcd_digit_updn.sv - single BCD digit cell with load, clear and up/down step
module bcd_digit_updn
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       load,
  input  bcd_digit_t ld_digit,
  input  logic       step,
  input  logic       up_dn,
  output bcd_digit_t digit,
  output logic       at_max,
  output logic       at_min
);

  // Digit register: reset/clear, then load, then a ripple step that rolls over at the limits
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      digit <= BCD_MIN;
    end else if (load) begin
      digit <= ld_digit;
    end else if (step) begin
      if (up_dn) begin
        digit <= (digit == BCD_MAX) ? BCD_MIN : digit + 4'd1;
      end else begin
        digit <= (digit == BCD_MIN) ? BCD_MAX : digit - 4'd1;
      end
    end
  end

  assign at_max = (digit == BCD_MAX);
  assign at_min = (digit == BCD_MIN);

endmodule

// File: rtl/bcd_counter_ndigit.sv
// rtl/bcd_counter_ndigit.sv - N-digit BCD up/down counter with wrap/saturate and overflow flag
module bcd_counter_ndigit
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SATURATE = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  en,
  input  logic                  up_dn,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tc,
  output logic                  ovf,
  output logic                  load_err
);

  localparam logic SAT_EN = (SATURATE != 0);

  logic [DIGITS-1:0]   at_max;
  logic [DIGITS-1:0]   at_min;
  logic [DIGITS-1:0]   step;
  logic [4*DIGITS-1:0] ld_clamped;
  logic                ld_bad;

  // Terminal count looks only at the live count, enable and direction
  assign tc = en & (up_dn ? (&at_max) : (&at_min));

  // Ripple-enable chain; in saturate mode the terminal event blocks every digit from stepping
  always_comb begin
    step    = '0;
    step[0] = en & ~(SAT_EN & tc);
    for (int k = 1; k < DIGITS; k++) begin
      step[k] = step[k-1] & (up_dn ? at_max[k-1] : at_min[k-1]);
    end
  end

  // Clamp each load nibble to 9 and flag whether any nibble needed clamping
  always_comb begin
    ld_clamped = '0;
    ld_bad     = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      ld_clamped[4*k +: 4] = bcd_clamp(load_val[4*k +: 4]);
      if (load_val[4*k +: 4] > BCD_MAX) begin
        ld_bad = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_updn u_digit (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .load     (load),
      .ld_digit (ld_clamped[4*g +: 4]),
      .step     (step[g]),
      .up_dn    (up_dn),
      .digit    (count[4*g +: 4]),
      .at_max   (at_max[g]),
      .at_min   (at_min[g])
    );
  end

  // Sticky overflow survives loads; load_err pulses only in the cycle after a clamped load
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      ovf      <= 1'b0;
      load_err <= 1'b0;
    end else if (load) begin
      load_err <= ld_bad;
    end else begin
      load_err <= 1'b0;
      if (tc) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bcd_counter_ndigit.sv
// tb/tb_bcd_counter_ndigit.sv - scoreboard bench for wrap and saturate counter variants
module tb_bcd_counter_ndigit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_val = '0;
  logic        en = 1'b0;
  logic        up_dn = 1'b0;

  logic [15:0] count_w, count_s;
  logic        tc_w, tc_s, ovf_w, ovf_s, lerr_w, lerr_s;

  always #5 clk = ~clk;

  bcd_counter_ndigit #(.DIGITS(4), .SATURATE(0)) dut_w (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .up_dn(up_dn), .count(count_w), .tc(tc_w), .ovf(ovf_w), .load_err(lerr_w)
  );

  bcd_counter_ndigit #(.DIGITS(4), .SATURATE(1)) dut_s (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .up_dn(up_dn), .count(count_s), .tc(tc_s), .ovf(ovf_s), .load_err(lerr_s)
  );

  typedef struct {
    bit          chk_tc;
    logic        tc_w;
    logic        tc_s;
    logic [15:0] cnt_w;
    logic        ovf_w;
    logic [15:0] cnt_s;
    logic        ovf_s;
    logic        lerr;
  } exp_t;

  exp_t exp_q[$];

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: counts as plain decimal integers
  int m_w = 0, m_s = 0;
  bit mo_w = 0, mo_s = 0;
  bit known = 0;

  function automatic logic [15:0] to_bcd(input int n);
    logic [15:0] r;
    r[3:0]   = 4'(n % 10);
    r[7:4]   = 4'((n / 10) % 10);
    r[11:8]  = 4'((n / 100) % 10);
    r[15:12] = 4'((n / 1000) % 10);
    return r;
  endfunction

  function automatic int load_to_int(input logic [15:0] v, output bit bad);
    int n = 0;
    int w = 1;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      int d = int'(v >> (4 * k)) & 15;
      if (d > 9) begin
        d = 9;
        bad = 1;
      end
      n += d * w;
      w *= 10;
    end
    return n;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus, advance the model and queue the expected response
  task automatic drive(input bit r, input bit c, input bit l, input logic [15:0] lv,
                       input bit e, input bit u);
    exp_t x;
    bit   bad;
    int   lvn;
    bit   term_w, term_s;
    @(negedge clk);
    rst = r; clr = c; load = l; load_val = lv; en = e; up_dn = u;
    term_w = e && (u ? (m_w == 9999) : (m_w == 0));
    term_s = e && (u ? (m_s == 9999) : (m_s == 0));
    x.chk_tc = known;
    x.tc_w = term_w;
    x.tc_s = term_s;
    lvn = load_to_int(lv, bad);
    x.lerr = 1'b0;
    if (r || c) begin
      m_w = 0; m_s = 0; mo_w = 0; mo_s = 0;
      known = 1;
    end else if (l) begin
      m_w = lvn; m_s = lvn;
      x.lerr = bad;
    end else if (e) begin
      if (term_w) begin
        m_w = u ? 0 : 9999;
        mo_w = 1;
      end else begin
        m_w = u ? m_w + 1 : m_w - 1;
      end
      if (term_s) mo_s = 1;
      else m_s = u ? m_s + 1 : m_s - 1;
    end
    x.cnt_w = to_bcd(m_w);
    x.cnt_s = to_bcd(m_s);
    x.ovf_w = mo_w;
    x.ovf_s = mo_s;
    exp_q.push_back(x);
  endtask

  // Monitor: tc checked mid-cycle against the pre-edge state, registers checked just after the edge
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() != 0) begin
        x = exp_q[0];
        if (x.chk_tc) begin
          chk("tc_wrap", {15'd0, tc_w}, {15'd0, x.tc_w});
          chk("tc_sat", {15'd0, tc_s}, {15'd0, x.tc_s});
        end
        @(posedge clk);
        #1;
        x = exp_q.pop_front();
        chk("count_wrap", count_w, x.cnt_w);
        chk("ovf_wrap", {15'd0, ovf_w}, {15'd0, x.ovf_w});
        chk("load_err_wrap", {15'd0, lerr_w}, {15'd0, x.lerr});
        chk("count_sat", count_s, x.cnt_s);
        chk("ovf_sat", {15'd0, ovf_s}, {15'd0, x.ovf_s});
        chk("load_err_sat", {15'd0, lerr_s}, {15'd0, x.lerr});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] lv;
    int sel;
    // reset, then idle
    drive(1, 0, 0, 16'h0000, 0, 1);
    drive(1, 0, 0, 16'h0000, 0, 1);
    drive(0, 0, 0, 16'h0000, 0, 1);
    // carry chain up then down
    drive(0, 0, 1, 16'h0999, 0, 1);
    drive(0, 0, 0, 16'h0000, 1, 1);
    drive(0, 0, 0, 16'h0000, 1, 0);
    // terminal up then down
    drive(0, 0, 1, 16'h9999, 0, 1);
    drive(0, 0, 0, 16'h0000, 1, 1);
    drive(0, 0, 0, 16'h0000, 1, 0);
    // clear, then down at zero for three cycles, then clear
    drive(0, 1, 0, 16'h0000, 0, 1);
    repeat (3) drive(0, 0, 0, 16'h0000, 1, 0);
    drive(0, 1, 0, 16'h0000, 0, 0);
    // clamped load then legal load and idle
    drive(0, 0, 1, 16'hA3F5, 0, 1);
    drive(0, 0, 1, 16'h1234, 0, 1);
    drive(0, 0, 0, 16'h0000, 0, 1);
    // priority cases
    drive(0, 1, 1, 16'h5555, 1, 1);
    drive(0, 0, 1, 16'h0777, 0, 1);
    drive(1, 0, 1, 16'h5555, 1, 1);
    drive(0, 0, 1, 16'h0042, 1, 1);
    drive(0, 0, 0, 16'h0000, 0, 0);
    // randomized traffic biased toward the terminal values
    for (int i = 0; i < 2000; i++) begin
      sel = int'($urandom_range(0, 3));
      case (sel)
        0: lv = 16'($urandom);
        1: lv = ($urandom_range(0, 1) != 0) ? 16'h9998 : 16'h0001;
        2: lv = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        default: lv = ($urandom_range(0, 1) != 0) ? 16'h9999 : 16'h0000;
      endcase
      drive($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 3,
            $urandom_range(0, 99) < 10, lv,
            $urandom_range(0, 99) < 75, $urandom_range(0, 1) != 0);
    end
    drive(0, 0, 0, 16'h0000, 0, 1);
    for (int w = 0; w < 10 && exp_q.size() != 0; w++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d expected responses left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
